// File: rtl/pong_pkg.sv
// pong_pkg: shared state encoding, winner codes, paddle hit codes and
// the speed-level helper for the Pong match sequencer.
package pong_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    localparam logic [1:0] HIT_P1 = 2'b01;
    localparam logic [1:0] HIT_P2 = 2'b10;

    function automatic logic [1:0] speed_of(input logic [7:0] rally, input int hits_per_level);
        int lvl;
        lvl = int'(rally) / hits_per_level;
        return (lvl > 3) ? 2'd3 : lvl[1:0];
    endfunction

endpackage

// File: rtl/tick_counter.sv
// tick_counter: loadable down-counter advanced by frame_tick, with a zero flag.
module tick_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_q, count_d;

    // A load on the same cycle as a tick wins, so the entry tick is not counted.
    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (tick && count_q != '0)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/pong_match_ctrl.sv
// pong_match_ctrl: Pong match sequencer - serve/point timing, ball step rate,
// rally speed-up, scoring and winner detection.
module pong_match_ctrl
    import pong_pkg::*;
#(
    parameter int WIN_SCORE      = 7,
    parameter int SERVE_TICKS    = 60,
    parameter int POINT_TICKS    = 90,
    parameter int HALF_H         = 180,
    parameter int BASE_DIV       = 4,
    parameter int HITS_PER_LEVEL = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       game_end,
    input  logic [1:0] paddle_hit,
    input  logic [9:0] ball_y,
    output logic       ball_rst,
    output logic       ball_adv,
    output logic [3:0] score1,
    output logic [3:0] score2,
    output logic [1:0] speed_level,
    output logic [1:0] winner,
    output logic [2:0] state
);

    state_e     state_q, state_d;
    logic       start_q;
    logic [7:0] div_q, div_d;
    logic [7:0] rally_q, rally_d;
    logic [3:0] score1_q, score1_d;
    logic [3:0] score2_q, score2_d;
    logic [1:0] winner_q, winner_d;
    logic [1:0] speed_q, speed_d;
    logic       ball_rst_q, ball_rst_d;
    logic       ball_adv_q, ball_adv_d;
    logic       cnt_load, cnt_zero;
    logic [7:0] cnt_val;
    logic [7:0] div_thr;
    logic       start_rise, expire;

    tick_counter #(.W(8)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .tick     (frame_tick),
        .load     (cnt_load),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    assign start_rise = start & ~start_q;
    assign expire     = frame_tick & cnt_zero;
    // Using >= keeps the divider bounded if the level rises mid-count.
    assign div_thr    = 8'(BASE_DIV - 1) - {6'd0, speed_q};

    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        rally_d    = rally_q;
        score1_d   = score1_q;
        score2_d   = score2_q;
        winner_d   = winner_q;
        ball_adv_d = 1'b0;
        cnt_load   = 1'b0;
        cnt_val    = 8'(SERVE_TICKS);
        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start_rise) begin
                    score1_d = '0;
                    score2_d = '0;
                    winner_d = WIN_NONE;
                    cnt_load = 1'b1;
                    state_d  = ST_SERVE;
                end
            end
            ST_SERVE: begin
                div_d   = '0;
                rally_d = '0;
                if (expire)
                    state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (game_end) begin
                    if (ball_y < 10'(HALF_H))
                        score2_d = score2_q + 4'd1;
                    else
                        score1_d = score1_q + 4'd1;
                    cnt_load = 1'b1;
                    cnt_val  = 8'(POINT_TICKS);
                    state_d  = ST_POINT;
                end else begin
                    if (paddle_hit != 2'b00 && rally_q != 8'hFF)
                        rally_d = rally_q + 8'd1;
                    if (frame_tick) begin
                        ball_adv_d = (div_q >= div_thr);
                        div_d      = (div_q >= div_thr) ? 8'd0 : div_q + 8'd1;
                    end
                end
            end
            ST_POINT: begin
                if (expire) begin
                    if (score1_q == 4'(WIN_SCORE) || score2_q == 4'(WIN_SCORE)) begin
                        winner_d = (score1_q == 4'(WIN_SCORE)) ? WIN_P1 : WIN_P2;
                        state_d  = ST_OVER;
                    end else begin
                        cnt_load = 1'b1;
                        state_d  = ST_SERVE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        ball_rst_d = (state_d == ST_IDLE) || (state_d == ST_SERVE) || (state_d == ST_OVER);
        speed_d    = speed_of(rally_d, HITS_PER_LEVEL);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            div_q      <= '0;
            rally_q    <= '0;
            score1_q   <= '0;
            score2_q   <= '0;
            winner_q   <= WIN_NONE;
            speed_q    <= '0;
            ball_rst_q <= 1'b1;
            ball_adv_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            div_q      <= div_d;
            rally_q    <= rally_d;
            score1_q   <= score1_d;
            score2_q   <= score2_d;
            winner_q   <= winner_d;
            speed_q    <= speed_d;
            ball_rst_q <= ball_rst_d;
            ball_adv_q <= ball_adv_d;
        end
    end

    assign ball_rst    = ball_rst_q;
    assign ball_adv    = ball_adv_q;
    assign score1      = score1_q;
    assign score2      = score2_q;
    assign speed_level = speed_q;
    assign winner      = winner_q;
    assign state       = state_q;

endmodule
